// File: rtl/debounce_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : debounce_pkg
// Brief   : Shared state encoding and width helper for the debounce filter.
// Revision: 1.0 - initial release
// ============================================================================
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    QUAL_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    QUAL_LOW    = 2'd3
  } deb_state_t;

  // Ceiling log2, usable in constant expressions for counter sizing.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_filter_sync_chain.sv
`default_nettype none
// ============================================================================
// Module  : sync_chain
// Brief   : N-flop shift-chain synchroniser for a single asynchronous bit.
// Revision: 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int   N           = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_DATA,
  output logic o_QOUT
);

  logic [N-1:0] r_chain;

  // No logic between stages so each flop gets a full cycle to resolve.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_chain <= {N{RESET_LEVEL}};
    end else begin
      r_chain <= {r_chain[N-2:0], i_DATA};
    end
  end

  assign o_QOUT = r_chain[N-1];

endmodule
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// Module  : debounce_filter
// Brief   : Synchronises a raw input and accepts a new level only after it
//           has been stable for STABLE_CYCLES consecutive samples.
// Revision: 1.0 - initial release
// ============================================================================
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 1000000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_DATA,
  output logic o_QOUT,
  output logic o_BUSY
);

  localparam int                 c_CNT_W = clog2(STABLE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_ZERO  = '0;

  logic               w_sync;
  deb_state_t         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_qout;
  logic               r_busy;

  sync_chain #(
    .N           (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .i_DATA (i_DATA),
    .o_QOUT (w_sync)
  );

  // The first qualifying sample counts as 1, so STABLE_CYCLES=1 accepts at once.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;
      r_cnt   <= c_ZERO;
      r_qout  <= RESET_LEVEL;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        STABLE_LOW: begin
          if (w_sync) begin
            if (STABLE_CYCLES == 1) begin
              r_qout  <= 1'b1;
              r_state <= STABLE_HIGH;
            end else begin
              r_state <= QUAL_HIGH;
              r_cnt   <= c_ONE;
              r_busy  <= 1'b1;
            end
          end
        end
        QUAL_HIGH: begin
          if (!w_sync) begin
            r_cnt   <= c_ZERO;
            r_state <= STABLE_LOW;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_LAST) begin
            r_qout  <= 1'b1;
            r_cnt   <= c_ZERO;
            r_state <= STABLE_HIGH;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!w_sync) begin
            if (STABLE_CYCLES == 1) begin
              r_qout  <= 1'b0;
              r_state <= STABLE_LOW;
            end else begin
              r_state <= QUAL_LOW;
              r_cnt   <= c_ONE;
              r_busy  <= 1'b1;
            end
          end
        end
        QUAL_LOW: begin
          if (w_sync) begin
            r_cnt   <= c_ZERO;
            r_state <= STABLE_HIGH;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_LAST) begin
            r_qout  <= 1'b0;
            r_cnt   <= c_ZERO;
            r_state <= STABLE_LOW;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        default: begin
          r_state <= STABLE_LOW;
          r_cnt   <= c_ZERO;
          r_qout  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_QOUT = r_qout;
  assign o_BUSY = r_busy;

endmodule
`default_nettype wire
